// File: rtl/noc_axi4_slave_mem_if.sv
// AXI4-style bus bundle for noc_axi4_slave_mem: AW/W/B write channels and AR/R read channels.
// Clock and reset are not part of the bundle; they stay plain ports on the slave.
interface noc_axi4_slave_mem_if;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;

    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;

    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    logic [3:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;

    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/noc_axi4_slave_mem.sv
// AXI4 burst slave backed by a DEPTH x 32-bit memory with independent write and read FSMs.
// Optional out-of-range address checking enabled by defining NOC_AXI_SLV_ADDR_CHK_EN.
module noc_axi4_slave_mem #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                 ACLK,
    input logic                 ASW_RESET,
    noc_axi4_slave_mem_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH];

    w_state_t    w_state;
    logic [3:0]  w_id, w_len, w_cnt;
    logic [1:0]  w_burst;
    logic [31:0] w_addr;
    logic        w_err;

    r_state_t    r_state;
    logic [3:0]  r_len, r_cnt;
    logic [1:0]  r_burst;
    logic [31:0] r_addr;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        mask = 32'({len, 2'b11});
        if (burst == 2'b00)
            return a;
        if (burst == 2'b10 && (len inside {4'd1, 4'd3, 4'd7, 4'd15}))
            return (a & ~mask) | ((a + 32'd4) & mask);
        return a + 32'd4;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] w_next, r_next;
    logic        w_beat, w_last_beat, w_err_next, mem_we;
    logic        w_in_range, ar_in_range, r_next_in_range;

    assign w_next = next_addr(w_addr, w_len, w_burst);
    assign r_next = next_addr(r_addr, r_len, r_burst);

`ifdef NOC_AXI_SLV_ADDR_CHK_EN
    assign w_in_range      = (w_addr - BASE_ADDR) < 32'(4 * DEPTH);
    assign ar_in_range     = (bus.ARADDR - BASE_ADDR) < 32'(4 * DEPTH);
    assign r_next_in_range = (r_next - BASE_ADDR) < 32'(4 * DEPTH);
`else
    assign w_in_range      = 1'b1;
    assign ar_in_range     = 1'b1;
    assign r_next_in_range = 1'b1;
`endif

    assign w_beat      = (w_state == W_DATA) && bus.WVALID && bus.WREADY;
    assign w_last_beat = (w_cnt == w_len);
    // WLAST is only audited; the beat counter alone terminates the burst.
    assign w_err_next  = w_err | (bus.WLAST != w_last_beat) | ~w_in_range;
    assign mem_we      = w_beat && w_in_range;

    // Memory array is deliberately not reset so data survives a reset pulse.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.WSTRB[b])
                    mem[word_idx(w_addr)][8*b +: 8] <= bus.WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ASW_RESET) begin
        if (ASW_RESET) begin
            w_state     <= W_IDLE;
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b0;
            bus.BVALID  <= 1'b0;
            bus.BRESP   <= '0;
            bus.BID     <= '0;
            w_id        <= '0;
            w_addr      <= '0;
            w_len       <= '0;
            w_cnt       <= '0;
            w_burst     <= '0;
            w_err       <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (bus.AWVALID && bus.AWREADY) begin
                        bus.AWREADY <= 1'b0;
                        bus.WREADY  <= 1'b1;
                        w_id        <= bus.AWID;
                        w_addr      <= bus.AWADDR;
                        w_len       <= bus.AWLEN;
                        w_burst     <= bus.AWBURST;
                        w_cnt       <= '0;
                        w_err       <= 1'b0;
                        w_state     <= W_DATA;
                    end else begin
                        bus.AWREADY <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_err <= w_err_next;
                        if (w_last_beat) begin
                            bus.WREADY <= 1'b0;
                            bus.BVALID <= 1'b1;
                            bus.BID    <= w_id;
                            bus.BRESP  <= w_err_next ? 2'b10 : 2'b00;
                            w_state    <= W_RESP;
                        end else begin
                            w_addr <= w_next;
                            w_cnt  <= w_cnt + 4'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bus.BVALID  <= 1'b0;
                        bus.BRESP   <= '0;
                        bus.AWREADY <= 1'b1;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ASW_RESET) begin
        if (ASW_RESET) begin
            r_state     <= R_IDLE;
            bus.ARREADY <= 1'b0;
            bus.RVALID  <= 1'b0;
            bus.RLAST   <= 1'b0;
            bus.RRESP   <= '0;
            bus.RID     <= '0;
            bus.RDATA   <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_burst     <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (bus.ARVALID && bus.ARREADY) begin
                        bus.ARREADY <= 1'b0;
                        bus.RID     <= bus.ARID;
                        r_addr      <= bus.ARADDR;
                        r_len       <= bus.ARLEN;
                        r_burst     <= bus.ARBURST;
                        r_cnt       <= '0;
                        bus.RVALID  <= 1'b1;
                        bus.RLAST   <= (bus.ARLEN == 4'd0);
                        bus.RDATA   <= ar_in_range ? mem[word_idx(bus.ARADDR)] : '0;
                        bus.RRESP   <= ar_in_range ? 2'b00 : 2'b10;
                        r_state     <= R_DATA;
                    end else begin
                        bus.ARREADY <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (bus.RREADY) begin
                        if (bus.RLAST) begin
                            bus.RVALID  <= 1'b0;
                            bus.RLAST   <= 1'b0;
                            bus.RRESP   <= '0;
                            bus.ARREADY <= 1'b1;
                            r_state     <= R_IDLE;
                        end else begin
                            r_addr    <= r_next;
                            r_cnt     <= r_cnt + 4'd1;
                            bus.RLAST <= ((r_cnt + 4'd1) == r_len);
                            bus.RDATA <= r_next_in_range ? mem[word_idx(r_next)] : '0;
                            bus.RRESP <= r_next_in_range ? 2'b00 : 2'b10;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule
